// File: rtl/fetch_prefetch_queue.sv
// MIPS fetch stage: one outstanding imem request, DEPTH-entry {pc, instr} queue towards decode.
// Optional FETCH_JUMP_PREDECODE_EN: follow J/JAL targets at push time instead of pc+4.
module fetch_prefetch_queue #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int DEPTH = 4,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic                       clk,
  input  logic                       reset,
  output logic                       imem_req,
  output logic [ADDR_W-1:0]          imem_addr,
  input  logic                       imem_ack,
  input  logic [DATA_W-1:0]          imem_rdata,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [ADDR_W-1:0]          out_pc,
  output logic [DATA_W-1:0]          out_instr,
  input  logic                       redirect_valid,
  input  logic [ADDR_W-1:0]          redirect_pc,
  output logic [$clog2(DEPTH+1)-1:0] fifo_count
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH+1);

  typedef enum logic [1:0] {ISSUE, WAIT, WAIT_DROP} state_t;

  state_t            state, state_nxt;
  logic [ADDR_W-1:0] fetch_pc, fetch_pc_nxt, req_addr, pc_plus4;
  logic [ADDR_W-1:0] pc_mem    [DEPTH];
  logic [DATA_W-1:0] instr_mem [DEPTH];
  logic [PTR_W-1:0]  head, tail;
  logic [CNT_W-1:0]  count;
  logic              full, push, pop;
  logic              redirect_lsb_unused;

  assign redirect_lsb_unused = ^redirect_pc[1:0];

  assign full       = (count == CNT_W'(DEPTH));
  assign out_valid  = (count != '0);
  assign fifo_count = count;
  assign out_pc     = pc_mem[head];
  assign out_instr  = instr_mem[head];

  // Outside ISSUE the request must stay up until acked, even if the queue is full
  always_comb begin
    imem_req = 1'b0;
    if (!reset) begin
      if (state == ISSUE) imem_req = !full;
      else                imem_req = 1'b1;
    end
  end

  // req_addr holds the in-flight address so a redirect during WAIT cannot disturb it
  assign imem_addr = (state == ISSUE) ? fetch_pc : req_addr;

  assign push     = imem_req & imem_ack & (state != WAIT_DROP) & !redirect_valid;
  assign pop      = out_valid & out_ready & !redirect_valid;
  assign pc_plus4 = fetch_pc + ADDR_W'(4);

`ifdef FETCH_JUMP_PREDECODE_EN
  logic [ADDR_W-1:0] jump_target;
  logic              is_jump;
  assign is_jump     = (imem_rdata[31:26] == 6'b000010) || (imem_rdata[31:26] == 6'b000011);
  assign jump_target = (pc_plus4 & ~ADDR_W'(28'hFFF_FFFF)) | ADDR_W'({imem_rdata[25:0], 2'b00});
`endif

  always_comb begin
    fetch_pc_nxt = fetch_pc;
    if (redirect_valid) begin
      fetch_pc_nxt = {redirect_pc[ADDR_W-1:2], 2'b00};
    end else if (push) begin
`ifdef FETCH_JUMP_PREDECODE_EN
      fetch_pc_nxt = is_jump ? jump_target : pc_plus4;
`else
      fetch_pc_nxt = pc_plus4;
`endif
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ISSUE: begin
        if (imem_req && !imem_ack) state_nxt = redirect_valid ? WAIT_DROP : WAIT;
      end
      WAIT: begin
        if (imem_ack)            state_nxt = ISSUE;
        else if (redirect_valid) state_nxt = WAIT_DROP;
      end
      WAIT_DROP: begin
        if (imem_ack) state_nxt = ISSUE;
      end
      default: state_nxt = ISSUE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= ISSUE;
      fetch_pc <= RESET_PC;
      req_addr <= RESET_PC;
      head     <= '0;
      tail     <= '0;
      count    <= '0;
    end else begin
      state    <= state_nxt;
      fetch_pc <= fetch_pc_nxt;
      if (state == ISSUE) req_addr <= fetch_pc;
      if (redirect_valid) begin
        head  <= '0;
        tail  <= '0;
        count <= '0;
      end else begin
        if (push) tail <= tail + PTR_W'(1);
        if (pop)  head <= head + PTR_W'(1);
        if (push && !pop)      count <= count + CNT_W'(1);
        else if (pop && !push) count <= count - CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        pc_mem[i]    <= '0;
        instr_mem[i] <= '0;
      end
    end else if (push) begin
      pc_mem[tail]    <= fetch_pc;
      instr_mem[tail] <= imem_rdata;
    end
  end
endmodule
